// File: rtl/prio_enc_nway_disp.sv
// N-input, K-rank priority encoder: scans a snapshot of the request bank one bit per cycle,
// commits the K highest asserted inputs atomically and shows them on a multiplexed 7-segment display.
module prio_enc_nway_disp #(
   parameter int N             = 12,
   parameter int K             = 2,
   parameter int DIGITS        = 4,
   parameter int PRESCALE_BITS = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req,
   input  logic              hold,
   output logic [DIGITS-1:0] an,
   output logic [7:0]        sseg
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = $clog2(K + 1);
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
   localparam logic [RW-1:0] K_R     = RW'(K);
   localparam logic [DW-1:0] DIG_TOP = DW'(DIGITS - 1);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         sync1_q, req_s_q;
   logic [N-1:0]         shadow_q, shadow_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [RW-1:0]        rank_q, rank_d;
   logic [K-1:0][3:0]    temp_q, temp_d;
   logic [K-1:0][3:0]    result_q, result_d;

   logic [PRESCALE_BITS-1:0] presc_q;
   logic [DW-1:0]            digit_q, digit_d;
   logic [DIGITS-1:0]        an_q, an_d;
   logic [7:0]               sseg_q, sseg_d;
   logic [7:0]               pos_seg [DIGITS];

   function automatic logic [6:0] hex_to_sseg(input logic [3:0] hex);
      logic [6:0] s;
      case (hex)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'ha: s = 7'b0001000;
         4'hb: s = 7'b1100000;
         4'hc: s = 7'b0110001;
         4'hd: s = 7'b1000010;
         4'he: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Requests are active low at the pins; invert before the two-flop synchronizer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         req_s_q <= '0;
      end else begin
         sync1_q <= ~req;
         req_s_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= LOAD;
         shadow_q <= '0;
         idx_q    <= IDX_TOP;
         rank_q   <= '0;
         temp_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         rank_q   <= rank_d;
         temp_q   <= temp_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      rank_d   = rank_q;
      temp_d   = temp_q;
      result_d = result_q;
      case (state_q)
         LOAD: begin
            shadow_d = req_s_q;
            idx_d    = IDX_TOP;
            rank_d   = '0;
            temp_d   = '0;
            state_d  = SCAN;
         end
         SCAN: begin
            if (shadow_q[idx_q] && (rank_q < K_R)) begin
               for (int k = 0; k < K; k++) begin
                  if (rank_q == RW'(k)) temp_d[k] = 4'(idx_q) + 4'd1;
               end
               rank_d = rank_q + RW'(1);
            end
            if (idx_q == '0) state_d = COMMIT;
            else             idx_d   = idx_q - IW'(1);
         end
         COMMIT: begin
            // hold only gates the commit; the scan keeps free-running
            if (!hold) result_d = temp_q;
            state_d = LOAD;
         end
         default: state_d = LOAD;
      endcase
   end

   // Per-position glyphs: result[0] lands on the leftmost used digit.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pos
         if (gi < K) begin : g_used
            assign pos_seg[gi] = (result_q[K-1-gi] == 4'd0) ? 8'hFE
                                                            : {1'b1, hex_to_sseg(result_q[K-1-gi])};
         end else begin : g_blank
            assign pos_seg[gi] = 8'hFF;
         end
      end
   endgenerate

   always_comb begin
      digit_d = digit_q;
      if (&presc_q) digit_d = (digit_q == DIG_TOP) ? '0 : digit_q + DW'(1);
      an_d   = ~(DIGITS'(1) << digit_q);
      sseg_d = pos_seg[digit_q];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         digit_q <= '0;
         an_q    <= '1;
         sseg_q  <= 8'hFF;
      end else begin
         presc_q <= presc_q + PRESCALE_BITS'(1);
         digit_q <= digit_d;
         an_q    <= an_d;
         sseg_q  <= sseg_d;
      end
   end

   assign an   = an_q;
   assign sseg = sseg_q;

endmodule

// File: tb/tb_prio_enc_nway_disp.sv
// Bench for prio_enc_nway_disp (N=12, K=2, DIGITS=4, fast prescaler): vector table,
// hand-written reset/hold/mid-scan sequences and randomized requests against a queue-based model.
module tb_prio_enc_nway_disp;
   localparam int N = 12;
   localparam int K = 2;
   localparam int DIGITS = 4;
   localparam int PB = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              hold = 1'b0;
   logic [N-1:0]      req = 12'hFF0;
   logic [DIGITS-1:0] an;
   logic [7:0]        sseg;

   int checks = 0;
   int failures = 0;
   logic [7:0] disp_seg [DIGITS];
   logic [DIGITS-1:0] disp_seen;

   always #5 clk = ~clk;

   prio_enc_nway_disp #(.N(N), .K(K), .DIGITS(DIGITS), .PRESCALE_BITS(PB)) dut (
      .clk(clk), .reset(reset), .req(req), .hold(hold), .an(an), .sseg(sseg)
   );

   typedef struct {
      string        name;
      logic [N-1:0] req;
      logic [3:0]   r0;
      logic [3:0]   r1;
   } vec_t;

   function automatic logic [7:0] glyph(input logic [3:0] v);
      logic [7:0] g;
      case (v)
         4'h0: g = 8'h81; 4'h1: g = 8'hCF; 4'h2: g = 8'h92; 4'h3: g = 8'h86;
         4'h4: g = 8'hCC; 4'h5: g = 8'hA4; 4'h6: g = 8'hA0; 4'h7: g = 8'h8F;
         4'h8: g = 8'h80; 4'h9: g = 8'h84; 4'ha: g = 8'h88; 4'hb: g = 8'hE0;
         4'hc: g = 8'hB1; 4'hd: g = 8'hC2; 4'he: g = 8'hB0; default: g = 8'hB8;
      endcase
      return g;
   endfunction

   // Reference: list asserted inputs from highest priority down, keep the first K.
   function automatic logic [7:0] model_res(input logic [N-1:0] req_n);
      int q[$];
      logic [3:0] r0, r1;
      for (int i = N - 1; i >= 0; i--) if (!req_n[i]) q.push_back(i + 1);
      r0 = (q.size() > 0) ? 4'(q[0]) : 4'd0;
      r1 = (q.size() > 1) ? 4'(q[1]) : 4'd0;
      return {r1, r0};
   endfunction

   function automatic logic [7:0] exp_seg(input logic [7:0] res, input int d);
      logic [3:0] v;
      if (d >= K) return 8'hFF;
      v = res[(K-1-d)*4 +: 4];
      return (v == 4'd0) ? 8'hFE : glyph(v);
   endfunction

   function automatic int an_index(input logic [DIGITS-1:0] a);
      for (int d = 0; d < DIGITS; d++) if (a == ~(DIGITS'(1) << d)) return d;
      return -1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Observe one full digit rotation, keeping the last glyph seen per position.
   task automatic read_display();
      int d;
      disp_seen = '0;
      for (int i = 0; i < DIGITS; i++) disp_seg[i] = 8'h00;
      for (int c = 0; c < DIGITS * (1 << PB) + 8; c++) begin
         @(negedge clk);
         d = an_index(an);
         if (d >= 0) begin
            disp_seg[d] = sseg;
            disp_seen[d] = 1'b1;
         end
      end
   endtask

   task automatic check_display(input string tag, input logic [7:0] res);
      read_display();
      check({tag, "_seen"}, 32'(disp_seen), 32'({DIGITS{1'b1}}));
      for (int d = 0; d < DIGITS; d++)
         check($sformatf("%s_dig%0d", tag, d), 32'(disp_seg[d]), 32'(exp_seg(res, d)));
   endtask

   task automatic apply(input logic [N-1:0] v);
      @(negedge clk);
      req = v;
      repeat (2 + 2 * (N + 2) + 4) @(negedge clk);
   endtask

   vec_t vecs[$];

   initial begin
      int d, prev, dwell;
      bit found;
      logic [N-1:0] ra, rb, rv;
      logic [7:0] ea, eb, er;

      vecs.push_back('{"c3",    ~12'b1000_0000_0100, 4'd12, 4'd3});
      vecs.push_back('{"all",   12'h000,             4'd12, 4'd11});
      vecs.push_back('{"none",  12'hFFF,             4'd0,  4'd0});
      vecs.push_back('{"bit0",  ~12'h001,            4'd1,  4'd0});
      vecs.push_back('{"bit5",  ~12'h020,            4'd6,  4'd0});

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_sseg", 32'(sseg), 32'hFF);
      check("rst_res", 32'(dut.result_q), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("first_an", 32'(an), 32'hE);
      check("first_sseg", 32'(sseg), 32'hFE);

      // Asynchronous reset in the middle of a scan
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (dut.idx_q == 4'd5) found = 1'b1;
      end
      check("midscan_reach", 32'(found), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("async_an", 32'(an), 32'hF);
      check("async_sseg", 32'(sseg), 32'hFF);
      check("async_res", 32'(dut.result_q), 32'h0);
      check("async_temp", 32'(dut.temp_q), 32'h0);
      check("async_idx", 32'(dut.idx_q), 32'(N - 1));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rel_res", 32'(dut.result_q), 32'h0);
      check("rel_an", 32'(an), 32'hE);
      check("rel_sseg", 32'(sseg), 32'hFE);

      // Table-driven vectors
      foreach (vecs[i]) begin
         apply(vecs[i].req);
         $display("vec %s req=%03h expect r0=%0d r1=%0d", vecs[i].name, vecs[i].req, vecs[i].r0, vecs[i].r1);
         check({vecs[i].name, "_res"}, 32'(dut.result_q), 32'({vecs[i].r1, vecs[i].r0}));
         check_display(vecs[i].name, {vecs[i].r1, vecs[i].r0});
         if (vecs[i].name == "c3") begin
            check("c3_glyphC", 32'(disp_seg[1]), 32'hB1);
            check("c3_glyph3", 32'(disp_seg[0]), 32'h86);
         end
         if (vecs[i].name == "bit0") check("bit0_glyph1", 32'(disp_seg[1]), 32'hCF);
      end

      // hold freezes committed results while the request moves from bit 5 to bit 9
      @(negedge clk);
      hold = 1'b1;
      req = ~12'h200;
      for (int p = 0; p < 4; p++) begin
         repeat (N + 2) @(negedge clk);
         check($sformatf("hold_p%0d", p), 32'(dut.result_q), 32'h06);
      end
      check_display("hold", 8'h06);
      hold = 1'b0;
      found = 1'b0;
      for (int c = 0; c < N + 2 && !found; c++) begin
         @(negedge clk);
         if (dut.result_q == 8'h0A) found = 1'b1;
      end
      check("hold_release", 32'(dut.result_q), 32'h0A);
      $display("hold sequence released, result=%02h", dut.result_q);
      check_display("unhold", 8'h0A);

      // Request change mid-scan must not leak into the committed result
      ra = ~12'h00A;
      rb = ~12'h005;
      ea = model_res(ra);
      eb = model_res(rb);
      apply(ra);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (dut.idx_q == 4'd6) found = 1'b1;
      end
      check("toggle_reach", 32'(found), 32'h1);
      req = rb;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("toggle_snap%0d", c), 32'(dut.result_q), 32'(ea));
      end
      repeat (2 * (N + 2)) @(negedge clk);
      check("toggle_next", 32'(dut.result_q), 32'(eb));
      $display("toggle A=%03h B=%03h committed %02h", ra, rb, dut.result_q);

      // Digit rotation order and dwell
      prev = -1;
      dwell = 0;
      for (int c = 0; c < 6 * (1 << PB); c++) begin
         @(negedge clk);
         d = an_index(an);
         if (d < 0) check("rot_onehot", 32'(an), 32'hE);
         else if (d != prev) begin
            if (prev >= 0) begin
               check($sformatf("rot_order%0d", prev), 32'(d), 32'((prev + 1) % DIGITS));
               if (dwell >= 0) check("rot_dwell", 32'(dwell), 32'(1 << PB));
            end
            dwell = (prev >= 0) ? 1 : -1000;
            prev = d;
         end else dwell++;
      end

      // Randomized requests against the reference model
      for (int i = 0; i < 24; i++) begin
         rv = N'($urandom);
         if (i % 3 == 1) rv = ~(N'($urandom) & N'($urandom) & N'($urandom));
         if (i % 3 == 2) rv = N'($urandom) | N'($urandom);
         er = model_res(rv);
         apply(rv);
         $display("rand %0d req=%03h expect=%02h", i, rv, er);
         check($sformatf("rand%0d_res", i), 32'(dut.result_q), 32'(er));
         if (i % 4 == 0) check_display($sformatf("rand%0d", i), er);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
